// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and
// segment bit positions on the led_data bus.
package seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int DP_BIT = 7;

   // Active-high glyphs, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to seven-segment decoder, active-high segments,
// all segments off when blank is set.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   logic [6:0] glyph;

   always_comb begin
      glyph = blank ? 7'h00 : SEG_TABLE[nibble];
      seg   = '0;
      seg[SEG_A] = glyph[0];
      seg[SEG_B] = glyph[1];
      seg[SEG_C] = glyph[2];
      seg[SEG_D] = glyph[3];
      seg[SEG_E] = glyph[4];
      seg[SEG_F] = glyph[5];
      seg[SEG_G] = glyph[6];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment display scanner with frame-synchronous update,
// leading-zero blanking and whole-display blinking.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int BLINK_FRAMES   = 64,
   parameter bit COM_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] lednum,
   input  logic                load,
   input  logic [DIGITS-1:0]   dp,
   input  logic                blank_lz,
   input  logic                blink_en,
   output logic [DIGITS-1:0]   led_com,
   output logic [7:0]          led_data,
   output logic                frame_done
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIGITS-1:0] COM_OFF = COM_ACTIVE_LOW ? '1 : '0;
   localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    digit_idx;
   logic                div_tc, last_digit, frame_bnd;
   logic [4*DIGITS-1:0] pend_num, disp_num;
   logic [DIGITS-1:0]   pend_dp, disp_dp;
   logic [BLK_W-1:0]    blink_cnt;
   logic                blink_on;
   logic [DIGITS-1:0]   lz_blank;
   logic                zero_run;
   logic [3:0]          cur_nib;
   logic                cur_dp, cur_blank;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   com_next;
   logic [7:0]          data_next;

   assign div_tc     = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign last_digit = (digit_idx == IDX_W'(DIGITS - 1));
   assign frame_bnd  = div_tc & last_digit;
   assign frame_done = frame_bnd & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt   <= '0;
         digit_idx <= '0;
      end else if (div_tc) begin
         div_cnt   <= '0;
         digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
      end else begin
         div_cnt   <= div_cnt + 1'b1;
      end
   end

   // A load landing on the boundary bypasses pending so it shows next frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_num <= '0;
         pend_dp  <= '0;
         disp_num <= '0;
         disp_dp  <= '0;
      end else begin
         if (load) begin
            pend_num <= lednum;
            pend_dp  <= dp;
         end
         if (frame_bnd) begin
            disp_num <= load ? lednum : pend_num;
            disp_dp  <= load ? dp : pend_dp;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (!blink_en) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (frame_bnd) begin
         if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Zero run is scanned from the most significant digit downward
   always_comb begin
      lz_blank  = '0;
      zero_run  = 1'b1;
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_run    = zero_run & (disp_num[4*i +: 4] == 4'h0);
         lz_blank[i] = zero_run;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_nib   = disp_num[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = blank_lz & lz_blank[i];
         end
      end
   end

   seg7_decode u_decode (
      .nibble (cur_nib),
      .blank  (cur_blank),
      .seg    (seg)
   );

   always_comb begin
      com_next = (blink_en && !blink_on) ? '0 : (DIGITS'(1) << digit_idx);
      data_next = '0;
      data_next[SEG_G:SEG_A] = seg;
      data_next[DP_BIT]      = cur_dp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_com  <= COM_OFF;
         led_data <= SEG_OFF;
      end else begin
         led_com  <= COM_ACTIVE_LOW ? ~com_next : com_next;
         led_data <= SEG_ACTIVE_LOW ? ~data_next : data_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2,
// both outputs active-low.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] lednum;
   logic        load;
   logic [3:0]  dp;
   logic        blank_lz;
   logic        blink_en;
   logic [3:0]  led_com;
   logic [7:0]  led_data;
   logic        frame_done;

   int n_chk = 0;
   int n_err = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   seg_scan_driver #(
      .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2),
      .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .lednum(lednum), .load(load), .dp(dp),
      .blank_lz(blank_lz), .blink_en(blink_en), .led_com(led_com),
      .led_data(led_data), .frame_done(frame_done)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // {led_com, led_data} expected while digit d is shown (active-low)
   function automatic logic [11:0] exp_digit(input logic [15:0] num, input logic [3:0] dpv,
                                             input bit blz, input int d);
      logic [6:0] s;
      logic [3:0] com;
      bit         blank;
      blank = 1'b0;
      if (blz && d > 0) begin
         blank = 1'b1;
         for (int j = d; j < 4; j++)
            if (num[4*j +: 4] != 4'h0) blank = 1'b0;
      end
      s   = blank ? 7'h00 : hex_seg(num[4*d +: 4]);
      com = ~(4'b0001 << d);
      return {com, ~{dpv[d], s}};
   endfunction

   task automatic push_digits(input logic [15:0] num, input logic [3:0] dpv, input bit blz, input int first);
      for (int d = first; d < 4; d++) exp_q.push_back(exp_digit(num, dpv, blz, d));
   endtask

   // Called at the first negedge on which digit 'first' is displayed
   task automatic check_digits(input int first);
      for (int d = first; d < 4; d++) begin
         logic [11:0] e;
         chk_val("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() == 0) return;
         e = exp_q.pop_front();
         chk_val($sformatf("com_d%0d", d), led_com, e[11:8]);
         chk_val($sformatf("data_d%0d", d), led_data, e[7:0]);
         if (d < 3) repeat (4) @(negedge clk);
      end
   endtask

   task automatic wait_frame();
      int k;
      k = 0;
      @(negedge clk);
      while (!frame_done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk_val("frame_seen", frame_done, 1);
   endtask

   task automatic do_load(input logic [15:0] num, input logic [3:0] dpv);
      lednum = num;
      dp     = dpv;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, fd;
      lednum = '0; dp = '0; load = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
      repeat (3) @(negedge clk);
      chk_val("rst_com", led_com, 4'hF);
      chk_val("rst_data", led_data, 8'hFF);
      chk_val("rst_fd", frame_done, 0);
      rst = 1'b0;

      // Basic load, shown from the first frame boundary
      do_load(16'h1234, 4'h0);
      push_digits(16'h1234, 4'h0, 0, 0);
      wait_frame();
      repeat (2) @(negedge clk);
      check_digits(0);

      // Frame period and single-cycle pulse
      wait_frame();
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_done && k < 40);
      chk_val("frame_period", k, 16);

      // Load exactly on the frame-boundary cycle
      do_load(16'h9E07, 4'b1001);
      push_digits(16'h9E07, 4'b1001, 0, 0);
      @(negedge clk);
      check_digits(0);

      // Mid-frame load: rest of current frame keeps the old value
      wait_frame();
      repeat (2) @(negedge clk);
      push_digits(16'h9E07, 4'b1001, 0, 1);
      do_load(16'hABCD, 4'h0);
      repeat (3) @(negedge clk);
      check_digits(1);
      push_digits(16'hABCD, 4'h0, 0, 0);
      wait_frame();
      repeat (2) @(negedge clk);
      check_digits(0);

      // Leading-zero blanking
      blank_lz = 1'b1;
      do_load(16'h0050, 4'h0);
      push_digits(16'h0050, 4'h0, 1, 0);
      wait_frame();
      repeat (2) @(negedge clk);
      check_digits(0);

      // Blanked digit still honours its decimal point
      do_load(16'h0003, 4'b0100);
      push_digits(16'h0003, 4'b0100, 1, 0);
      wait_frame();
      repeat (2) @(negedge clk);
      check_digits(0);

      // Blinking: 32 cycles dark, 32 cycles scanning, frame_done continues
      blink_en = 1'b1;
      k = 0;
      while (led_com != 4'hF && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk_val("blink_start", led_com, 4'hF);
      k = 0; fd = 0;
      while (led_com == 4'hF && k < 100) begin
         k++;
         if (frame_done) fd++;
         @(negedge clk);
      end
      chk_val("blink_off_len", k, 32);
      chk_val("blink_off_fd", fd, 2);
      k = 0; fd = 0;
      while (led_com != 4'hF && k < 100) begin
         k++;
         if (frame_done) fd++;
         @(negedge clk);
      end
      chk_val("blink_on_len", k, 32);
      chk_val("blink_on_fd", fd, 2);
      blink_en = 1'b0;
      @(negedge clk);
      chk_val("blink_release", led_com == 4'hF, 0);

      // Reset mid-frame while digit 2 is displayed
      blank_lz = 1'b0;
      k = 0;
      while (led_com != 4'b1011 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk_val("reach_d2", led_com, 4'b1011);
      #2 rst = 1'b1;
      #1;
      chk_val("mid_rst_com", led_com, 4'hF);
      chk_val("mid_rst_data", led_data, 8'hFF);
      chk_val("mid_rst_fd", frame_done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_val("post_rst_com", led_com, 4'b1110);
      chk_val("post_rst_data", led_data, 8'hC0);
      k = 1;
      while (!frame_done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk_val("post_rst_first_frame", k, 15);
      push_digits(16'h0000, 4'h0, 0, 0);
      repeat (2) @(negedge clk);
      check_digits(0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each digit is held active, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: full frames per blink half-period.
REQ-004 Parameter COM_ACTIVE_LOW, default 1: when 1, led_com drives 0 to enable a digit.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1: when 1, led_data drives 0 to light a segment.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-007 clk  in  1  system clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 lednum  in  4*DIGITS  hex nibbles; nibble 0 (LSBs) is the rightmost digit.
REQ-010 load  in  1  one-cycle strobe that captures lednum and dp.
REQ-011 dp  in  DIGITS  decimal-point request per digit.
REQ-012 blank_lz  in  1  enables leading-zero blanking.
REQ-013 blink_en  in  1  enables whole-display blinking.
REQ-014 led_com  out  DIGITS  digit enables, one-hot in active polarity.
REQ-015 led_data  out  8  segments: bit0=a through bit6=g, bit7=dp.
REQ-016 frame_done  out  1  one-cycle pulse when the last digit's dwell completes.

Function
REQ-017 The divider counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance by one.
REQ-018 The digit index SHALL wrap from DIGITS-1 to 0; that wrap cycle is the frame boundary.
REQ-019 frame_done SHALL be high for exactly the frame-boundary cycle.
REQ-020 On load, lednum and dp SHALL be captured into a pending register.
REQ-021 At each frame boundary, the pending register SHALL be copied into the display register, so no frame ever shows mixed values.
REQ-022 If load coincides with a frame boundary, the display register SHALL take lednum and dp directly that cycle; the pending register is updated too.
REQ-023 led_com and led_data SHALL be registered and SHALL reflect a new digit index one cycle after the index changes.
REQ-024 Segment decode SHALL follow the standard hex table in active-high form: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
REQ-025 Bit7 of led_data SHALL be the display register's dp bit for the current digit.
REQ-026 SEG_ACTIVE_LOW and COM_ACTIVE_LOW SHALL invert the final output only.
REQ-027 Leading-zero blanking: when blank_lz=1, digit i>0 SHALL be blanked (segments off, dp still honoured) if nibbles DIGITS-1 down to i are all zero.
REQ-028 Digit 0 is never blanked.
REQ-029 Blink phase SHALL toggle every BLINK_FRAMES frame boundaries.
REQ-030 While blink_en=1 and the phase is off, all led_com SHALL be inactive; scanning and frame_done continue unaffected.
REQ-031 When blink_en goes to 0, the phase SHALL reset to on at the next cycle.
REQ-032 blank_lz and blink_en are sampled live, not shadowed.

Reset
REQ-033 rst SHALL asynchronously clear the divider, digit index, blink counter, pending register and display register, and set the blink phase to on.
REQ-034 During reset, led_com and led_data SHALL be all-inactive (in configured polarity) and frame_done SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; after release, scanning restarts at digit 0, divider 0.

Structure
REQ-036 The shared package seg_pkg SHALL hold the 16-entry segment table, the segment bit-position constants and the DP bit index.
REQ-037 Sub-module seg7_decode (combinational: nibble plus blank in, 7 active-high segments out) SHALL be instantiated once, on the muxed current nibble.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, both polarities active-low)
REQ-038 Load lednum=0x1234 after reset -> from the first frame boundary, digit0 drives led_data=~0x66 with led_com=4'b1110, digit3 drives ~0x06; frame_done pulses every 16 cycles.
REQ-039 Load 0x0050 with blank_lz=1 -> digits 3 and 2 show led_data=0xFF, digit1 shows ~0x6D, digit0 shows ~0x3F.
REQ-040 Load 0xABCD mid-frame -> the current frame keeps the old value; the change appears only after frame_done.
REQ-041 load on the frame-boundary cycle -> the new value is visible on digit 0 in the immediately following frame.
REQ-042 blink_en=1 -> led_com=4'b1111 for 32 cycles, then scanning for 32 cycles, repeating; frame_done is uninterrupted.
REQ-043 Assert rst at digit 2 -> led_com=4'b1111 and led_data=0xFF immediately; after release, digit 0 is active again one cycle later.
